product_accumulator: RTL and testbench

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

---
 rtl/karatsuba_defs.sv | 12 +
 rtl/multiply.sv | 12 +
 rtl/product_accumulator.sv | 114 +++++++++++
 tb/tb_product_accumulator.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/karatsuba_defs.sv
// Shared definitions for the product accumulator: FSM encoding and default widths.
package karatsuba_defs;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_ACC_W = 24;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_e;

endpackage

// File: rtl/multiply.sv
// Combinational unsigned multiplier producing a full-width 2*WIDTH product.
module multiply #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] p
);

  assign p = a * b;

endmodule

// File: rtl/product_accumulator.sv
// Frame-based multiply-accumulate: registered operands, combinational multiply,
// wrapping accumulator with sticky overflow, result held until the consumer takes it.
module product_accumulator
  import karatsuba_defs::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] sum,
  output logic             overflow
);

  generate
    if (ACC_W < 2 * WIDTH) begin : g_bad_width
      $error("product_accumulator: ACC_W must be at least 2*WIDTH");
    end
  endgenerate

  // Sum with carry-out; the extra top bit is the overflow indication.
  function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0] acc,
                                             input logic [2*WIDTH-1:0] prod);
    return {1'b0, acc} + {{(ACC_W + 1 - 2 * WIDTH){1'b0}}, prod};
  endfunction

  acc_state_e         state, state_nxt;
  logic               accept;
  logic               vld_p1;
  logic               last_p1;
  logic [WIDTH-1:0]   a_p1, b_p1;
  logic [2*WIDTH-1:0] prod_p1;
  logic [ACC_W-1:0]   acc_p2;
  logic               ovf_p2;
  logic [ACC_W:0]     add_p1;
  logic               release_hs;

  // A last beat sitting in stage 1 blocks new beats until the frame closes.
  always_comb begin
    in_ready   = !rst && (state == ACCUM) && !(vld_p1 && last_p1);
    accept     = in_valid && in_ready;
    release_hs = (state == HOLD) && out_ready;
  end

  // ---- stage 1: operand capture ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= accept;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      a_p1    <= A;
      b_p1    <= B;
      last_p1 <= in_last;
    end
  end

  multiply #(.WIDTH(WIDTH)) u_mul (
    .a (a_p1),
    .b (b_p1),
    .p (prod_p1)
  );

  assign add_p1 = acc_add(acc_p2, prod_p1);

  // ---- stage 2: accumulate ----
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_p2 <= '0;
      ovf_p2 <= 1'b0;
    end else if (release_hs) begin
      acc_p2 <= '0;
      ovf_p2 <= 1'b0;
    end else if (vld_p1) begin
      acc_p2 <= add_p1[ACC_W-1:0];
      ovf_p2 <= ovf_p2 | add_p1[ACC_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACCUM;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM: if (vld_p1 && last_p1) state_nxt = HOLD;
      HOLD:  if (out_ready)         state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  always_comb begin
    out_valid = !rst && (state == HOLD);
    sum       = out_valid ? acc_p2 : '0;
    overflow  = out_valid ? ovf_p2 : 1'b0;
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Randomised and directed bench for product_accumulator; two instances (ACC_W=24
// and ACC_W=17) share one stimulus stream and are checked against a frame-level model.
module tb_product_accumulator;

  localparam logic [63:0] M24 = 64'hFF_FFFF;
  localparam logic [63:0] M17 = 64'h1_FFFF;

  logic        clk, rst, in_valid, in_last, out_ready;
  logic [7:0]  A, B;
  logic        rdy24, ov24, of24, rdy17, ov17, of17;
  logic [23:0] sum24;
  logic [16:0] sum17;

  product_accumulator dut24 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy24), .A(A), .B(B),
    .in_last(in_last), .out_valid(ov24), .out_ready(out_ready), .sum(sum24),
    .overflow(of24)
  );

  product_accumulator #(.WIDTH(8), .ACC_W(17)) dut17 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy17), .A(A), .B(B),
    .in_last(in_last), .out_valid(ov17), .out_ready(out_ready), .sum(sum17),
    .overflow(of17)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  // Frame-level model: unbounded running sum, result latched when the frame closes.
  logic        m_hold = 1'b0;
  logic [63:0] m_res  = '0;
  logic [63:0] m_acc  = '0;
  logic        m_s1v  = 1'b0;
  logic        m_s1last = 1'b0;
  logic [63:0] m_s1prod = '0;

  // Observations of the DUT used by the hand-computed literal checks.
  logic [63:0] hs_sum24, hs_sum17;
  logic        hs_of24, hs_of17;
  logic        last_rdy, prev_ov;
  int          rise_cyc, acc_cyc, valid_cnt;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc_n, got, exp);
    end
  endtask

  task automatic compare_outputs();
    logic        e_rdy, e_ov;
    logic [63:0] e_s24, e_s17;
    logic        e_of24, e_of17;
    e_rdy  = !rst && !m_hold && !(m_s1v && m_s1last);
    e_ov   = !rst && m_hold;
    e_s24  = e_ov ? (m_res & M24) : 64'd0;
    e_s17  = e_ov ? (m_res & M17) : 64'd0;
    e_of24 = e_ov && (m_res > M24);
    e_of17 = e_ov && (m_res > M17);
    chk("in_ready24", 64'(rdy24), 64'(e_rdy));
    chk("in_ready17", 64'(rdy17), 64'(e_rdy));
    chk("out_valid24", 64'(ov24), 64'(e_ov));
    chk("out_valid17", 64'(ov17), 64'(e_ov));
    chk("sum24", 64'(sum24), e_s24);
    chk("sum17", 64'(sum17), e_s17);
    chk("overflow24", 64'(of24), 64'(e_of24));
    chk("overflow17", 64'(of17), 64'(e_of17));
    last_rdy = rdy24;
    if (ov24) valid_cnt++;
    if (ov24 && !prev_ov) rise_cyc = cyc_n;
    prev_ov = ov24;
    if (ov24 && out_ready) begin
      hs_sum24 = 64'(sum24);
      hs_sum17 = 64'(sum17);
      hs_of24  = of24;
      hs_of17  = of17;
    end
  endtask

  // One clock cycle: drive, check, then advance the model across the rising edge.
  task automatic tick(input logic v, input logic [7:0] a, input logic [7:0] b,
                      input logic l, input logic ordy, input logic r, output logic acc);
    in_valid  = v;
    A         = a;
    B         = b;
    in_last   = l;
    out_ready = ordy;
    rst       = r;
    #1;
    compare_outputs();
    acc = !r && v && !m_hold && !(m_s1v && m_s1last);
    if (acc) acc_cyc = cyc_n;
    @(posedge clk);
    if (r) begin
      m_hold = 1'b0; m_acc = '0; m_res = '0; m_s1v = 1'b0; m_s1last = 1'b0;
    end else begin
      if (m_hold && ordy) begin
        m_hold = 1'b0;
        m_acc  = '0;
      end
      if (m_s1v) begin
        m_acc = m_acc + m_s1prod;
        if (m_s1last) begin
          m_hold = 1'b1;
          m_res  = m_acc;
        end
      end
      m_s1v    = acc;
      m_s1last = l;
      m_s1prod = 64'(a) * 64'(b);
    end
    cyc_n++;
    @(negedge clk);
  endtask

  task automatic idle(input logic ordy, input int n);
    logic ok;
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 8'h00, 1'b0, ordy, 1'b0, ok);
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic l,
                      input logic ordy);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) tick(1'b1, a, b, l, ordy, 1'b0, ok);
    if (!ok) chk("send_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    logic ok;
    int   beats;
    prev_ov = 1'b0; valid_cnt = 0; rise_cyc = -1; acc_cyc = -1;
    hs_sum24 = '0; hs_sum17 = '0; hs_of24 = 1'b0; hs_of17 = 1'b0; last_rdy = 1'b0;
    in_valid = 1'b0; A = '0; B = '0; in_last = 1'b0; out_ready = 1'b0; rst = 1'b1;
    @(negedge clk);

    // Reset, then the first cycle out of reset must be ready.
    for (int i = 0; i < 3; i++) tick(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, ok);
    idle(1'b1, 1);
    chk("ready_after_rst", 64'(last_rdy), 64'd1);

    // Single-beat frame and its latency.
    send(8'h55, 8'hCC, 1'b1, 1'b1);
    idle(1'b1, 4);
    chk("f1_sum", hs_sum24, 64'h0043BC);
    chk("f1_ovf", 64'(hs_of24), 64'd0);
    chk("f1_latency", 64'(rise_cyc - acc_cyc), 64'd2);

    // Three-beat frame, result valid one cycle.
    valid_cnt = 0;
    send(8'd3, 8'd4, 1'b0, 1'b1);
    send(8'd5, 8'd6, 1'b0, 1'b1);
    send(8'd7, 8'd8, 1'b1, 1'b1);
    idle(1'b1, 4);
    chk("f2_sum", hs_sum24, 64'h62);
    chk("f2_valid_cycles", 64'(valid_cnt), 64'd1);

    // Back-pressure: result held for 5 refused cycles, taken on the 6th.
    valid_cnt = 0;
    send(8'd2, 8'd2, 1'b1, 1'b0);
    idle(1'b0, 6);
    idle(1'b1, 3);
    chk("f3_sum", hs_sum24, 64'h4);
    chk("f3_valid_cycles", 64'(valid_cnt), 64'd6);

    // Wrap at 17 bits with sticky overflow; next frame starts clean.
    send(8'hFF, 8'hFF, 1'b0, 1'b1);
    send(8'hFF, 8'hFF, 1'b0, 1'b1);
    send(8'hFF, 8'hFF, 1'b1, 1'b1);
    idle(1'b1, 4);
    chk("f4_sum17", hs_sum17, 64'h0FA03);
    chk("f4_ovf17", 64'(hs_of17), 64'd1);
    chk("f4_sum24", hs_sum24, 64'h2FA03);
    chk("f4_ovf24", 64'(hs_of24), 64'd0);
    send(8'd1, 8'd1, 1'b1, 1'b1);
    idle(1'b1, 4);
    chk("f5_sum17", hs_sum17, 64'h1);
    chk("f5_ovf17", 64'(hs_of17), 64'd0);

    // Reset mid-frame discards the partial sum.
    send(8'd9, 8'd9, 1'b0, 1'b1);
    send(8'd9, 8'd9, 1'b0, 1'b1);
    tick(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, ok);
    send(8'd1, 8'd2, 1'b1, 1'b1);
    idle(1'b1, 4);
    chk("f6_sum", hs_sum24, 64'h2);

    // Back-to-back 3-beat frames with in_valid and out_ready held high.
    beats = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1'b1, 8'($urandom), 8'($urandom), (beats % 3) == 2, 1'b1, 1'b0, ok);
      if (ok) beats++;
    end
    idle(1'b1, 4);

    // Random traffic with occasional reset, biased toward large operands.
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] ra, rb;
      ra = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(240, 255)) : 8'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(240, 255)) : 8'($urandom);
      tick($urandom_range(0, 3) != 0, ra, rb, $urandom_range(0, 4) == 0,
           $urandom_range(0, 2) != 0, $urandom_range(0, 149) == 0, ok);
    end
    idle(1'b1, 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
